// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI mode-0 slave receiver: FSM state encodings and default frame width.
package spi_slave_rx_pkg;

  localparam int SPI_DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    S_ARM   = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_slave_rx_sync_edge.sv
// Multi-flop input synchronizer followed by one edge register; exposes synced level, rise and fall.
module spi_slave_rx_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    dly_d  = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, oversampled in the clk domain; one-cycle strobe per complete frame.
// Defining SPI_RX_MISO_EN adds a miso port that echoes the previously accepted word.
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int DATA_W      = SPI_DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
`ifdef SPI_RX_MISO_EN
  ,
  output logic              miso
`endif
);

  localparam int                  CNT_W      = $clog2(DATA_W + 2);
  localparam int                  FLUSH_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_DATA   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DATA_W + 1);
  localparam logic [FLUSH_W-1:0]  FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [FLUSH_W-1:0]  FLUSH_INIT = FLUSH_W'(SYNC_STAGES);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_lvl, cs_rise_unused, cs_fall_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_lvl),
    .rise  (cs_rise_unused),
    .fall  (cs_fall_unused)
  );

  spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
`ifdef SPI_RX_MISO_EN
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
`else
  logic                sclk_fall_unused;
  assign sclk_fall_unused = sclk_fall;
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef SPI_RX_MISO_EN
    tx_d        = tx_q;
`endif
    case (state_q)
      // The cs synchronizer resets to idle-high, so its output is only trusted once the
      // reset value has been flushed out; otherwise a frame in flight would look freshly started.
      S_ARM: begin
        if (flush_q != '0) begin
          flush_d = flush_q - FLUSH_ONE;
        end else if (cs_lvl) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!cs_lvl) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef SPI_RX_MISO_EN
          tx_d    = rx_data_q;
`endif
        end
      end
      S_SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[DATA_W-2:0], mosi_lvl};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end
`ifdef SPI_RX_MISO_EN
        if (sclk_fall) tx_d = {tx_q[DATA_W-2:0], 1'b0};
`endif
        // A bit clocked in the release cycle still counts toward the frame.
        if (cs_lvl) begin
          if (cnt_d == CNT_DATA) begin
            rx_data_d  = shreg_d;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_ARM;
    endcase
    busy_d = (state_d == S_SHIFT);
`ifdef SPI_RX_MISO_EN
    miso_d = (state_d == S_SHIFT) ? tx_d[DATA_W-1] : 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ARM;
      shreg_q     <= '0;
      cnt_q       <= '0;
      flush_q     <= FLUSH_INIT;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_RX_MISO_EN
      tx_q        <= '0;
      miso_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef SPI_RX_MISO_EN
      tx_q        <= tx_d;
      miso_q      <= miso_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef SPI_RX_MISO_EN
  assign miso      = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: scripted and randomized SPI frames against a frame-level model.
module tb_spi_slave_rx;

  localparam int DW   = 16;
  localparam int SYNC = 2;

  logic          clk, rst, sclk, mosi, cs;
  logic [DW-1:0] rx_data;
  logic          rx_valid, frame_err, busy;
`ifdef SPI_RX_MISO_EN
  logic          miso;
  logic [DW-1:0] miso_word;
`endif

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs        (cs),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef SPI_RX_MISO_EN
    ,
    .miso      (miso)
`endif
  );

  typedef struct {
    bit            is_valid;
    logic [DW-1:0] data;
    int            t0;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] shown_data;
  int            checks, failures;
  int            cyc, cs_change_cyc;
  int            n_valid, n_err;
  bit            ignore_frame, prev_pulse, rst_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison of the DUT against the frame-level expectations.
  always @(negedge clk) begin
    ev_t ev;
    int  age, lat;
    age = cyc - cs_change_cyc;
    if (rst) begin
      if (rst_prev) begin
        check("rst_outputs", {rx_data, rx_valid, frame_err, busy}, 0);
`ifdef SPI_RX_MISO_EN
        check("rst_miso", miso, 0);
`endif
      end
      shown_data = '0;
      prev_pulse = 1'b0;
    end else begin
      if (rx_valid && frame_err) check("valid_err_exclusive", 1, 0);
      if (rx_valid || frame_err) begin
        if (rx_valid) n_valid++;
        if (frame_err) n_err++;
        check("pulse_not_consecutive", prev_pulse, 0);
        check("busy_low_at_pulse", busy, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {rx_valid, frame_err}, 0);
        end else begin
          ev  = exp_q.pop_front();
          lat = cyc - ev.t0;
          check("pulse_kind", rx_valid, ev.is_valid);
          // pin-to-strobe measured in whole clk periods; one period of slack for pin phase
          check("pulse_latency", (lat >= SYNC + 1 && lat <= SYNC + 2), 1);
          if (ev.is_valid) shown_data = ev.data;
        end
      end
      check("rx_data", rx_data, shown_data);
      if (ignore_frame) check("busy_ignored_frame", busy, 0);
      else if (age >= SYNC + 3) check("busy_level", busy, !cs);
`ifdef SPI_RX_MISO_EN
      if (cs && age >= SYNC + 3) check("miso_idle", miso, 0);
`endif
      prev_pulse = rx_valid || frame_err;
    end
    rst_prev = rst;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("event_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic raise_cs(input bit dropped, input int n, input logic [31:0] bits);
    ev_t ev;
    if (!dropped) begin
      ev.is_valid = (n == DW);
      ev.data     = ev.is_valid ? bits[DW-1:0] : '0;
      ev.t0       = cyc;
      exp_q.push_back(ev);
    end
    cs            = 1'b1;
    cs_change_cyc = cyc;
    ignore_frame  = 1'b0;
  endtask

  // n bits of `bits`, MSB first; rst_at >= 0 pulses reset before that bit.
  task automatic send_frame(input logic [31:0] bits, input int n, input int half,
                            input bit simul, input int rst_at);
    logic [DW-1:0] echo;
    bit            dropped;
    echo    = shown_data;
    dropped = 1'b0;
    cs            = 1'b0;
    cs_change_cyc = cyc;
    wait_cycles($urandom_range(5, 8));
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst          = 1'b1;
        dropped      = 1'b1;
        ignore_frame = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
      end
      mosi = bits[n-1-i];
      wait_cycles(half);
`ifdef SPI_RX_MISO_EN
      if (i < DW) begin
        miso_word = {miso_word[DW-2:0], miso};
        if (!dropped) check("miso_bit", miso, echo[DW-1-i]);
      end
`endif
      sclk = 1'b1;
      if (simul && i == n - 1) raise_cs(dropped, n, bits);
      wait_cycles(half);
      sclk = 1'b0;
    end
    if (!(simul && n > 0)) begin
      wait_cycles($urandom_range(2, 5));
      raise_cs(dropped, n, bits);
    end
    drain();
    wait_cycles($urandom_range(8, 20));
  endtask

  initial begin
    int v0, e0, n, half;
    logic [31:0] bits;
    checks = 0; failures = 0; cyc = 0; cs_change_cyc = 0;
    n_valid = 0; n_err = 0; ignore_frame = 0; prev_pulse = 0; rst_prev = 0;
    shown_data = '0;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(8);
    check("reset_state", {rx_data, rx_valid, frame_err, busy}, 0);

    v0 = n_valid; e0 = n_err;
    send_frame(32'hA5C3, 16, 50, 0, -1);
    check("a5c3_data", rx_data, 16'hA5C3);
    check("a5c3_counts", {n_valid - v0, n_err - e0}, {32'd1, 32'd0});

    v0 = n_valid; e0 = n_err;
    send_frame(32'h0001, 16, 5, 0, -1);
    check("b2b_first", rx_data, 16'h0001);
    send_frame(32'hFFFF, 16, 5, 0, -1);
    check("b2b_second", rx_data, 16'hFFFF);
    check("b2b_counts", {n_valid - v0, n_err - e0}, {32'd2, 32'd0});

    v0 = n_valid; e0 = n_err;
    send_frame(32'h1ABC, 15, 4, 0, -1);
    check("short_keeps_data", rx_data, 16'hFFFF);
    send_frame(32'h1ABCD, 17, 4, 0, -1);
    send_frame(32'h0, 0, 4, 0, -1);
    check("err_counts", {n_valid - v0, n_err - e0}, {32'd0, 32'd3});

    v0 = n_valid; e0 = n_err;
    send_frame(32'h1234, 16, 4, 0, 8);
    check("rst_frame_dropped", {n_valid - v0, n_err - e0}, 0);
    check("rst_data_cleared", rx_data, 16'h0000);
    send_frame(32'h5678, 16, 4, 0, -1);
    check("after_rst_data", rx_data, 16'h5678);

    send_frame(32'h3C5A, 16, 4, 1, -1);
    check("simul_release_accepts", rx_data, 16'h3C5A);

`ifdef SPI_RX_MISO_EN
    send_frame(32'hBEEF, 16, 4, 0, -1);
    send_frame(32'h0F0F, 16, 4, 0, -1);
    check("miso_echo_beef", miso_word, 16'hBEEF);
`endif

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        6:       n = 15;
        7:       n = 17;
        8:       n = 0;
        9:       n = $urandom_range(1, 20);
        default: n = 16;
      endcase
      bits = $urandom;
      half = $urandom_range(4, 7);
      send_frame(bits, n, half, ($urandom_range(0, 3) == 0),
                 (n > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
